// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline stall/flush/forward control with load-use FSM, memory freeze and event counters
module hazard_ctrl_unit #(
  parameter int REG_AW            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              id_ex_memread,
  input  logic [REG_AW-1:0] id_ex_rs,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic              ex_mem_regwrite,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              mem_wb_regwrite,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              ex_branch,
  input  logic              ex_branch_taken,
  input  logic              id_jump,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              pipe_freeze,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Bubbles still owed after the first one, which is issued from IDLE.
  localparam logic [3:0]       LU_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state, r_saved_state;
  state_t           w_state_nxt, w_saved_state_nxt, w_cur_state;
  logic [3:0]       r_lu_cnt, r_saved_lu;
  logic [3:0]       w_lu_nxt, w_saved_lu_nxt, w_cur_lu;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_lu_hit, w_freeze, w_branch;

  assign w_freeze  = mem_req & ~mem_ready;
  assign w_branch  = ex_branch & ex_branch_taken;
  assign w_lu_hit  = id_ex_memread & (id_ex_rt != '0) &
                     ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // State, bubble counter and the context parked while memory holds the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_saved_state <= IDLE;
      r_lu_cnt      <= 4'd0;
      r_saved_lu    <= 4'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_saved_state <= w_saved_state_nxt;
      r_lu_cnt      <= w_lu_nxt;
      r_saved_lu    <= w_saved_lu_nxt;
    end
  end

  // Next state and pipeline controls; in MEM_WAIT the parked context is the
  // one evaluated, so the release cycle acts exactly as if never frozen.
  always_comb begin
    w_cur_state       = (r_state == MEM_WAIT) ? r_saved_state : r_state;
    w_cur_lu          = (r_state == MEM_WAIT) ? r_saved_lu : r_lu_cnt;
    pc_write          = 1'b1;
    if_id_write       = 1'b1;
    id_ex_bubble      = 1'b0;
    pipe_freeze       = 1'b0;
    if_flush          = 1'b0;
    id_flush          = 1'b0;
    ex_flush          = 1'b0;
    w_state_nxt       = w_cur_state;
    w_lu_nxt          = w_cur_lu;
    w_saved_state_nxt = r_saved_state;
    w_saved_lu_nxt    = r_saved_lu;
    if (w_freeze) begin
      pipe_freeze       = 1'b1;
      pc_write          = 1'b0;
      if_id_write       = 1'b0;
      w_state_nxt       = MEM_WAIT;
      w_lu_nxt          = r_lu_cnt;
      w_saved_state_nxt = w_cur_state;
      w_saved_lu_nxt    = w_cur_lu;
    end else if (w_branch) begin
      if_flush    = 1'b1;
      id_flush    = 1'b1;
      ex_flush    = 1'b1;
      w_state_nxt = IDLE;
      w_lu_nxt    = 4'd0;
    end else if (id_jump) begin
      if_flush    = 1'b1;
      w_state_nxt = IDLE;
      w_lu_nxt    = 4'd0;
    end else if (w_cur_state == LU_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (w_cur_lu <= 4'd1) begin
        w_state_nxt = IDLE;
        w_lu_nxt    = 4'd0;
      end else begin
        w_lu_nxt = w_cur_lu - 4'd1;
      end
    end else if (w_lu_hit) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        w_state_nxt = LU_STALL;
        w_lu_nxt    = LU_INIT;
      end
    end
  end

  // EX operand bypass: the younger producer in EX/MEM beats MEM/WB.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rs))
      forward_a = 2'b10;
    else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rs))
      forward_a = 2'b01;
    if (ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == id_ex_rt))
      forward_b = 2'b10;
    else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rt))
      forward_b = 2'b01;
  end

  // Saturating bubble and fetch-flush event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (id_ex_bubble && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (if_flush && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;
  localparam int AW  = 5;
  localparam int LSC = 3;

  localparam logic [6:0] NORM  = 7'b1100000;
  localparam logic [6:0] STALL = 7'b0010000;
  localparam logic [6:0] FRZ   = 7'b0001000;
  localparam logic [6:0] BR    = 7'b1100111;
  localparam logic [6:0] JMP   = 7'b1100100;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, ex_mem_rd, mem_wb_rd;
  logic if_id_uses_rt, id_ex_memread, ex_mem_regwrite, mem_wb_regwrite;
  logic ex_branch, ex_branch_taken, id_jump, mem_req, mem_ready;

  logic pc_write, if_id_write, id_ex_bubble, pipe_freeze, if_flush, id_flush, ex_flush;
  logic [1:0] forward_a, forward_b;
  logic [15:0] stall16, flush16;
  logic s_pc, s_ifid, s_bub, s_frz, s_iff, s_idf, s_exf;
  logic [1:0] s_fa, s_fb;
  logic [1:0] stall2, flush2;
  logic [6:0] ctrl_vec;

  int n_checks = 0;
  int n_errors = 0;
  int pend, m_stall, m_flush;
  logic [6:0] e_ctrl;
  logic [1:0] e_fa, e_fb;
  logic m_hit;

  always #5 clk = ~clk;

  assign ctrl_vec = {pc_write, if_id_write, id_ex_bubble, pipe_freeze, if_flush, id_flush, ex_flush};

  hazard_ctrl_unit #(.REG_AW(AW), .LOAD_STALL_CYCLES(LSC), .CNT_W(16)) dut16 (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread), .id_ex_rs(id_ex_rs),
    .id_ex_rt(id_ex_rt), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd), .ex_branch(ex_branch),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .if_flush(if_flush),
    .id_flush(id_flush), .ex_flush(ex_flush), .forward_a(forward_a), .forward_b(forward_b),
    .stall_cnt(stall16), .flush_cnt(flush16));

  hazard_ctrl_unit #(.REG_AW(AW), .LOAD_STALL_CYCLES(LSC), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread), .id_ex_rs(id_ex_rs),
    .id_ex_rt(id_ex_rt), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd), .ex_branch(ex_branch),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_write(s_pc), .if_id_write(s_ifid),
    .id_ex_bubble(s_bub), .pipe_freeze(s_frz), .if_flush(s_iff),
    .id_flush(s_idf), .ex_flush(s_exf), .forward_a(s_fa), .forward_b(s_fb),
    .stall_cnt(stall2), .flush_cnt(flush2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Latest writer of a register wins; r0 is never a bypass source.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
    if (src == 0) return 2'b00;
    if (ex_mem_regwrite && ex_mem_rd == src) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Reference model: "pend" is how many more forced bubbles are owed.
  always @(negedge clk) begin
    if (reset) begin
      pend = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_hit = id_ex_memread && (id_ex_rt != 0) &&
              ((id_ex_rt == if_id_rs) || (if_id_uses_rt && id_ex_rt == if_id_rt));
      if (mem_req && !mem_ready) e_ctrl = FRZ;
      else if (ex_branch && ex_branch_taken) begin e_ctrl = BR; pend = 0; end
      else if (id_jump) begin e_ctrl = JMP; pend = 0; end
      else if (pend > 0) begin e_ctrl = STALL; pend = pend - 1; end
      else if (m_hit) begin e_ctrl = STALL; pend = LSC - 1; end
      else e_ctrl = NORM;
      e_fa = fwd_sel(id_ex_rs);
      e_fb = fwd_sel(id_ex_rt);
      chk("ctrl", {25'd0, ctrl_vec}, {25'd0, e_ctrl});
      chk("ctrl_w2", {25'd0, s_pc, s_ifid, s_bub, s_frz, s_iff, s_idf, s_exf}, {25'd0, e_ctrl});
      chk("fwd", {28'd0, forward_a, forward_b}, {28'd0, e_fa, e_fb});
      chk("stall_cnt16", {16'd0, stall16}, sat(m_stall, 16));
      chk("flush_cnt16", {16'd0, flush16}, sat(m_flush, 16));
      chk("stall_cnt2", {30'd0, stall2}, sat(m_stall, 2));
      chk("flush_cnt2", {30'd0, flush2}, sat(m_flush, 2));
      if (e_ctrl[4]) m_stall++;
      if (e_ctrl[2]) m_flush++;
    end
  end

  task automatic clear();
    if_id_rs = 0; if_id_rt = 0; id_ex_rs = 0; id_ex_rt = 0; ex_mem_rd = 0; mem_wb_rd = 0;
    if_id_uses_rt = 0; id_ex_memread = 0; ex_mem_regwrite = 0; mem_wb_regwrite = 0;
    ex_branch = 0; ex_branch_taken = 0; id_jump = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic chk_ctrl(input string name, input logic [6:0] e);
    chk(name, {25'd0, ctrl_vec}, {25'd0, e});
  endtask

  initial begin
    reset = 1'b1;
    clear();
    tick(); tick();
    chk_ctrl("reset_ctrl", NORM);
    chk("reset_fwd", {28'd0, forward_a, forward_b}, 32'd0);
    chk("reset_cnt", {stall16, flush16}, 32'd0);
    reset = 1'b0;

    // forwarding priority
    tick(); clear();
    ex_mem_regwrite = 1; ex_mem_rd = 3; mem_wb_regwrite = 1; mem_wb_rd = 3; id_ex_rs = 3;
    look(); chk("fwd_exmem", {30'd0, forward_a}, 32'd2);
    tick(); ex_mem_rd = 0;
    look(); chk("fwd_memwb", {30'd0, forward_a}, 32'd1);

    // load-use, three bubbles
    tick(); clear(); id_ex_memread = 1; id_ex_rt = 5; if_id_rs = 5;
    look(); chk_ctrl("lu_c1", STALL);
    tick(); look(); chk_ctrl("lu_c2", STALL);
    tick(); look(); chk_ctrl("lu_c3", STALL);
    tick(); clear(); look(); chk_ctrl("lu_done", NORM);
    chk("lu_stall16", {16'd0, stall16}, 32'd3);
    chk("lu_stall2", {30'd0, stall2}, 32'd3);

    // false hazards, then a real rt hazard
    tick(); clear(); id_ex_memread = 1; id_ex_rt = 0; if_id_rs = 0;
    look(); chk_ctrl("fh_r0", NORM);
    tick(); id_ex_rt = 7; if_id_rt = 7; if_id_rs = 1; if_id_uses_rt = 0;
    look(); chk_ctrl("fh_no_rt", NORM);
    tick(); if_id_uses_rt = 1;
    look(); chk_ctrl("hz_rt", STALL);
    tick(); clear(); tick(); tick(); look(); chk_ctrl("hz_rt_done", NORM);
    chk("hz_rt_stall16", {16'd0, stall16}, 32'd6);

    // taken branch cancels the remaining bubble
    tick(); id_ex_memread = 1; id_ex_rt = 5; if_id_rs = 5;
    look(); chk_ctrl("br_c1", STALL);
    tick(); look(); chk_ctrl("br_c2", STALL);
    tick(); clear(); ex_branch = 1; ex_branch_taken = 1;
    look(); chk_ctrl("br_flush", BR);
    tick(); clear(); look(); chk_ctrl("br_after", NORM);
    chk("br_stall16", {16'd0, stall16}, 32'd8);
    chk("br_flush16", {16'd0, flush16}, 32'd1);

    // freeze holds a taken branch until memory is ready
    tick(); mem_req = 1; mem_ready = 0; ex_branch = 1; ex_branch_taken = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      look(); chk_ctrl("frz_hold", FRZ);
    end
    tick(); mem_ready = 1;
    look(); chk_ctrl("frz_release", BR);
    tick(); clear(); look();
    chk("frz_flush16", {16'd0, flush16}, 32'd2);

    // jumps saturate the narrow counter
    tick(); id_jump = 1;
    for (int i = 0; i < 5; i++) begin
      look(); chk_ctrl("jump", JMP);
      tick();
    end
    clear(); look();
    chk("sat_flush2", {30'd0, flush2}, 32'd3);
    chk("sat_flush16", {16'd0, flush16}, 32'd7);

    // asynchronous reset in the middle of LU_STALL
    tick(); id_ex_memread = 1; id_ex_rt = 9; if_id_rs = 9;
    look(); chk_ctrl("rs_c1", STALL);
    tick(); clear();
    look(); chk_ctrl("rs_hold", STALL);
    reset = 1'b1; #1;
    chk_ctrl("rs_ctrl", NORM);
    chk("rs_cnt16", {stall16, flush16}, 32'd0);
    chk("rs_cnt2", {28'd0, stall2, flush2}, 32'd0);
    tick(); tick(); reset = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      if_id_rs        = AW'($urandom_range(0, 3));
      if_id_rt        = AW'($urandom_range(0, 3));
      id_ex_rs        = AW'($urandom_range(0, 3));
      id_ex_rt        = AW'($urandom_range(0, 3));
      ex_mem_rd       = AW'($urandom_range(0, 3));
      mem_wb_rd       = AW'($urandom_range(0, 3));
      if_id_uses_rt   = 1'($urandom_range(0, 1));
      id_ex_memread   = ($urandom_range(0, 2) == 0);
      ex_mem_regwrite = 1'($urandom_range(0, 1));
      mem_wb_regwrite = 1'($urandom_range(0, 1));
      ex_branch       = ($urandom_range(0, 7) == 0);
      ex_branch_taken = 1'($urandom_range(0, 1));
      id_jump         = ($urandom_range(0, 9) == 0);
      mem_req         = ($urandom_range(0, 3) == 0);
      mem_ready       = 1'($urandom_range(0, 1));
    end
    tick(); clear();
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
